// File: rtl/layer_compositor.sv
// Pipelined NL-layer alpha compositor for the VGA pixel stream, bottom layer first, one stage per layer.
// Optional: define COMPOSITOR_DITHER_EN to replace the fixed rounding bias with a 2x2 ordered dither.
module layer_compositor #(
  parameter int CW       = 4,
  parameter int AW       = 3,
  parameter int NL       = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 de_i,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  input  logic [3*CW-1:0]      bg_rgb_i,
  input  logic [NL*3*CW-1:0]   fg_rgb_i,
  input  logic [NL*AW-1:0]     fg_alpha_i,
  input  logic [NL-1:0]        layer_en_i,
  output logic [3*CW-1:0]      rgb_o,
  output logic                 de_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic [NL-1:0]        mask_o
);

  localparam int C3 = 3*CW;
  localparam int SW = CW+AW+1;
  localparam logic ACT   = SYNC_POL;
  localparam logic INACT = ~SYNC_POL;
  localparam logic [AW:0]   W_ONE    = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] BIAS_RND = {1'b1, {(AW-1){1'b0}}};

  // Full-scale alpha is promoted to 2^AW so the top code reproduces fg exactly.
  function automatic logic [CW-1:0] blend_ch(input logic [CW-1:0] fg, input logic [CW-1:0] bg,
                                             input logic [AW-1:0] a, input logic [AW-1:0] bias);
    logic [AW:0]   w;
    logic [SW-1:0] sum;
    w   = (a == {AW{1'b1}}) ? W_ONE : {1'b0, a};
    sum = SW'(fg) * SW'(w) + SW'(bg) * SW'(W_ONE - w) + SW'(bias);
    return CW'(sum >> AW);
  endfunction

  function automatic logic [C3-1:0] blend_rgb(input logic [C3-1:0] fg, input logic [C3-1:0] bg,
                                              input logic [AW-1:0] a, input logic [AW-1:0] bias);
    logic [C3-1:0] res;
    res = '0;
    for (int c = 0; c < 3; c++)
      res[c*CW +: CW] = blend_ch(fg[c*CW +: CW], bg[c*CW +: CW], a, bias);
    return res;
  endfunction

  logic              vs_act, vs_prev, vs_edge;
  logic [NL-1:0]     mask_q;
  logic [NL*AW-1:0]  a_gated;

  assign vs_act  = (vsync_i == ACT);
  assign vs_edge = vs_act & ~vs_prev;
  assign mask_o  = mask_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vs_prev <= 1'b0;
      mask_q  <= '0;
    end else begin
      vs_prev <= vs_act;
      if (vs_edge) mask_q <= layer_en_i;
    end
  end

  // Mask applied at entry, so every layer of a pixel sees the same frame's mask.
  always_comb begin
    a_gated = '0;
    for (int k = 0; k < NL; k++)
      a_gated[k*AW +: AW] = mask_q[k] ? fg_alpha_i[k*AW +: AW] : '0;
  end

`ifdef COMPOSITOR_DITHER_EN
  logic          hs_prev, line_par, pix_par;
  logic [1:0]    dith;
  logic [AW-1:0] bias_in;
  logic [AW-1:0] bias_p [NL];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hs_prev  <= 1'b0;
      line_par <= 1'b0;
      pix_par  <= 1'b0;
    end else begin
      hs_prev <= (hsync_i == ACT);
      if (vs_edge)
        line_par <= 1'b0;
      else if ((hsync_i == ACT) && !hs_prev)
        line_par <= ~line_par;
      pix_par <= de_i ? ~pix_par : 1'b0;
    end
  end

  always_comb begin
    case ({line_par, pix_par})
      2'b00:   dith = 2'd0;
      2'b01:   dith = 2'd2;
      2'b10:   dith = 2'd3;
      default: dith = 2'd1;
    endcase
  end

  assign bias_in = AW'(dith) << (AW-2);
`endif

  logic [C3-1:0] acc_p [NL];
  logic          vld_p [NL];
  logic          hs_p  [NL];
  logic          vs_p  [NL];

  for (genvar k = 0; k < NL; k++) begin : g_stg
    logic [C3-1:0] acc_s, fg_s;
    logic [AW-1:0] a_s, bias_s;
    logic          vld_s, hs_s, vs_s;

    if (k == 0) begin : g_head
      assign acc_s = bg_rgb_i;
      assign fg_s  = fg_rgb_i[0 +: C3];
      assign a_s   = a_gated[0 +: AW];
      assign vld_s = de_i;
      assign hs_s  = hsync_i;
      assign vs_s  = vsync_i;
    end else begin : g_body
      localparam int FW = k*C3;
      localparam int DW = k*AW;
      logic [k-1:0][C3-1:0] fg_d;
      logic [k-1:0][AW-1:0] a_d;

      // Layer k arrives with the pixel; hold it k cycles so it meets the accumulator.
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          fg_d <= '0;
          a_d  <= '0;
        end else begin
          fg_d <= FW'({fg_d, fg_rgb_i[k*C3 +: C3]});
          a_d  <= DW'({a_d, a_gated[k*AW +: AW]});
        end
      end

      assign acc_s = acc_p[k-1];
      assign fg_s  = fg_d[k-1];
      assign a_s   = a_d[k-1];
      assign vld_s = vld_p[k-1];
      assign hs_s  = hs_p[k-1];
      assign vs_s  = vs_p[k-1];
    end

`ifdef COMPOSITOR_DITHER_EN
    if (k == 0) begin : g_bias_head
      assign bias_s = bias_in;
    end else begin : g_bias_body
      assign bias_s = bias_p[k-1];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) bias_p[k] <= '0;
      else         bias_p[k] <= bias_s;
    end
`else
    assign bias_s = BIAS_RND;
`endif

    // ---- stage k: blend layer k over the accumulated colour ----
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        acc_p[k] <= '0;
        vld_p[k] <= 1'b0;
        hs_p[k]  <= INACT;
        vs_p[k]  <= INACT;
      end else begin
        acc_p[k] <= blend_rgb(fg_s, acc_s, a_s, bias_s);
        vld_p[k] <= vld_s;
        hs_p[k]  <= hs_s;
        vs_p[k]  <= vs_s;
      end
    end
  end

  // ---- output register: blanking forces black ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rgb_o   <= '0;
      de_o    <= 1'b0;
      hsync_o <= INACT;
      vsync_o <= INACT;
    end else begin
      rgb_o   <= vld_p[NL-1] ? acc_p[NL-1] : '0;
      de_o    <= vld_p[NL-1];
      hsync_o <= hs_p[NL-1];
      vsync_o <= vs_p[NL-1];
    end
  end

endmodule
